// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: receiver FSM states, pixel width and default line timing.
// Used by the receiver, the transmitter and the pixel data source.
package ws2812_pkg;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    HIGH,
    LOW
  } rx_state_e;

  localparam int WS_W_DATA     = 24;
  localparam int WS_T_THRESH   = 60;
  localparam int WS_T_HIGH_MIN = 15;
  localparam int WS_T_HIGH_MAX = 120;
  localparam int WS_T_RESET    = 5000;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/ws2812_rx_edge.sv
// Line conditioning for the WS2812 receiver: 2-flop synchronizer, optional 3-sample
// majority filter (WS2812_RX_GLITCH_FILTER_EN) and rise/fall detection on the result.
module ws2812_rx_edge
  import ws2812_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_reg;
  logic       line;
  logic       line_d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], din};
    end
  end

`ifdef WS2812_RX_GLITCH_FILTER_EN
  // Majority over the current and two previous samples, registered: single-cycle
  // pulses never reach the FSM, clean edges arrive two cycles later.
  logic [1:0] hist_reg;
  logic       filt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_reg <= '0;
      filt_reg <= 1'b0;
    end else begin
      hist_reg <= {hist_reg[0], sync_reg[1]};
      filt_reg <= majority3(sync_reg[1], hist_reg[0], hist_reg[1]);
    end
  end

  assign line = filt_reg;
`else
  assign line = sync_reg[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_d_reg <= 1'b0;
    end else begin
      line_d_reg <= line;
    end
  end

  assign level = line;
  assign rise  = line & ~line_d_reg;
  assign fall  = ~line & line_d_reg;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 serial receiver: decodes high-pulse widths into 24-bit pixels, tracks the pixel
// index within a frame and flags protocol errors. Optional glitch filter: WS2812_RX_GLITCH_FILTER_EN.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int W_ADDR     = 6,
  parameter int W_DATA     = WS_W_DATA,
  parameter int T_THRESH   = WS_T_THRESH,
  parameter int T_HIGH_MIN = WS_T_HIGH_MIN,
  parameter int T_HIGH_MAX = WS_T_HIGH_MAX,
  parameter int T_RESET    = WS_T_RESET
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  output logic              pix_valid,
  output logic [W_DATA-1:0] pix_data,
  output logic [W_ADDR-1:0] pix_addr,
  output logic              frame_done,
  output logic              err,
  output logic              busy
);

  localparam int CW = $clog2(T_RESET + 1);
  localparam int BW = $clog2(W_DATA + 1);

  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] RESET_CNT  = CW'(T_RESET);
  localparam logic [CW-1:0] THRESH_CNT = CW'(T_THRESH);
  localparam logic [CW-1:0] HMIN_CNT   = CW'(T_HIGH_MIN);
  localparam logic [CW-1:0] HOVER_CNT  = CW'(T_HIGH_MAX + 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(W_DATA - 1);

  logic level, rise, fall;

  ws2812_rx_edge u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  rx_state_e         state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next, cnt_inc;
  logic [BW-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [W_DATA-1:0] shift_reg, shift_next;
  logic [W_ADDR-1:0] addr_reg, addr_next;
  logic [W_DATA-1:0] pix_data_reg, pix_data_next;
  logic [W_ADDR-1:0] pix_addr_reg, pix_addr_next;
  logic              pix_valid_reg, pix_valid_next;
  logic              frame_done_reg, frame_done_next;
  logic              err_reg, err_next;
  logic              busy_reg, busy_next;

  // Saturating increment; width counts never wrap back into the legal range.
  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    addr_next       = addr_reg;
    pix_data_next   = pix_data_reg;
    pix_addr_next   = pix_addr_reg;
    pix_valid_next  = 1'b0;
    frame_done_next = 1'b0;
    err_next        = 1'b0;

    case (state_reg)
      SYNC: begin
        if (level) begin
          cnt_next = '0;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc >= RESET_CNT) begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
      end

      IDLE: begin
        if (rise) begin
          state_next = HIGH;
          cnt_next   = CW'(1);
        end
      end

      HIGH: begin
        if (fall) begin
          // The falling-edge cycle is the first low cycle of the gap.
          state_next = LOW;
          cnt_next   = CW'(1);
          if (cnt_reg < HMIN_CNT) begin
            err_next     = 1'b1;
            bit_cnt_next = '0;
          end else begin
            shift_next = {shift_reg[W_DATA-2:0], (cnt_reg >= THRESH_CNT)};
            if (bit_cnt_reg == LAST_BIT) begin
              bit_cnt_next   = '0;
              pix_valid_next = 1'b1;
              pix_data_next  = shift_next;
              pix_addr_next  = addr_reg;
              addr_next      = addr_reg + 1'b1;
            end else begin
              bit_cnt_next = bit_cnt_reg + 1'b1;
            end
          end
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc >= HOVER_CNT) begin
            // Stuck-high line: abandon the frame and wait for a full latch gap.
            err_next     = 1'b1;
            bit_cnt_next = '0;
            addr_next    = '0;
            state_next   = SYNC;
            cnt_next     = '0;
          end
        end
      end

      LOW: begin
        if (rise) begin
          state_next = HIGH;
          cnt_next   = CW'(1);
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc >= RESET_CNT) begin
            state_next      = IDLE;
            cnt_next        = '0;
            frame_done_next = 1'b1;
            err_next        = (bit_cnt_reg != '0);
            bit_cnt_next    = '0;
            addr_next       = '0;
            pix_addr_next   = '0;
          end
        end
      end

      default: begin
        state_next = SYNC;
        cnt_next   = '0;
      end
    endcase

    busy_next = (state_next == HIGH) || (state_next == LOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= SYNC;
      cnt_reg        <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      addr_reg       <= '0;
      pix_data_reg   <= '0;
      pix_addr_reg   <= '0;
      pix_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      err_reg        <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      addr_reg       <= addr_next;
      pix_data_reg   <= pix_data_next;
      pix_addr_reg   <= pix_addr_next;
      pix_valid_reg  <= pix_valid_next;
      frame_done_reg <= frame_done_next;
      err_reg        <= err_next;
      busy_reg       <= busy_next;
    end
  end

  assign pix_valid  = pix_valid_reg;
  assign pix_data   = pix_data_reg;
  assign pix_addr   = pix_addr_reg;
  assign frame_done = frame_done_reg;
  assign err        = err_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx: drives WS2812 waveforms and compares the strobe
// sequence against a protocol-level model of the line (widths -> bits -> pixels/frames).
`timescale 1ns/1ps
module tb_ws2812_rx;

  localparam int T_THRESH   = 60;
  localparam int T_HIGH_MIN = 15;
  localparam int T_HIGH_MAX = 120;
  localparam int T_RESET    = 5000;
`ifdef WS2812_RX_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic [5:0]  pix_addr;
  logic        frame_done;
  logic        err;
  logic        busy;

  ws2812_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_addr   (pix_addr),
    .frame_done (frame_done),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          pv;
    bit          fd;
    bit          er;
    logic [23:0] data;
    logic [5:0]  addr;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  // Line-level model state
  bit          m_active;
  bit          m_inframe;
  int          m_low_run;
  int          m_nbits;
  int          m_addr;
  logic [23:0] m_acc;
  logic [23:0] m_last;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (pix_valid === 1'b1 || frame_done === 1'b1 || err === 1'b1) begin
      e.cyc  = cyc;
      e.pv   = (pix_valid === 1'b1);
      e.fd   = (frame_done === 1'b1);
      e.er   = (err === 1'b1);
      e.data = pix_data;
      e.addr = pix_addr;
      obs_q.push_back(e);
    end
  end

  task automatic check(string tag, logic [63:0] observed, logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic push_ev(bit pv, bit fd, bit er, logic [23:0] d, logic [5:0] a);
    ev_t e;
    e.cyc  = 0;
    e.pv   = pv;
    e.fd   = fd;
    e.er   = er;
    e.data = d;
    e.addr = a;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_active  = 0;
    m_inframe = 0;
    m_low_run = 0;
    m_nbits   = 0;
    m_addr    = 0;
    m_acc     = '0;
  endtask

  task automatic model_high(int n);
    m_low_run = 0;
    if (m_active) begin
      m_inframe = 1;
      if (n > T_HIGH_MAX) begin
        push_ev(0, 0, 1, '0, '0);
        m_nbits   = 0;
        m_addr    = 0;
        m_active  = 0;
        m_inframe = 0;
      end else if (n < T_HIGH_MIN) begin
        push_ev(0, 0, 1, '0, '0);
        m_nbits = 0;
      end else begin
        m_acc = {m_acc[22:0], (n >= T_THRESH)};
        m_nbits++;
        if (m_nbits == 24) begin
          push_ev(1, 0, 0, m_acc, 6'(m_addr));
          m_last  = m_acc;
          m_addr  = (m_addr + 1) % 64;
          m_nbits = 0;
        end
      end
    end
  endtask

  task automatic model_low(int n);
    m_low_run += n;
    if (!m_active) begin
      if (m_low_run >= T_RESET) m_active = 1;
    end else if (m_inframe && m_low_run >= T_RESET) begin
      push_ev(0, 1, (m_nbits != 0), '0, '0);
      m_nbits   = 0;
      m_addr    = 0;
      m_inframe = 0;
    end
  endtask

  task automatic drive(bit v, int n);
    din = v;
    if (v) model_high(n);
    else   model_low(n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(int hi, int lo);
    drive(1'b1, hi);
    drive(1'b0, lo);
  endtask

  task automatic send_fast(bit b);
    int hi;
    hi = b ? int'($urandom_range(60, 90)) : int'($urandom_range(15, 59));
    send_bit(hi, int'($urandom_range(10, 30)));
  endtask

  task automatic send_pixel(logic [23:0] d);
    for (int i = 23; i >= 0; i--) send_fast(d[i]);
  endtask

  task automatic glitch();
    din = 1'b1;
`ifdef WS2812_RX_GLITCH_FILTER_EN
    model_low(1);
`else
    model_high(1);
`endif
    @(negedge clk);
  endtask

  task automatic check_events(string tag);
    drive(1'b0, 12);
    check($sformatf("%s count", tag), 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s ev%0d pv/fd/err", tag, i),
            {obs_q[i].pv, obs_q[i].fd, obs_q[i].er}, {exp_q[i].pv, exp_q[i].fd, exp_q[i].er});
      if (exp_q[i].pv) begin
        check($sformatf("%s ev%0d data", tag, i), obs_q[i].data, exp_q[i].data);
        check($sformatf("%s ev%0d addr", tag, i), obs_q[i].addr, exp_q[i].addr);
      end
    end
    $display("%s: %0d events observed, %0d expected", tag, obs_q.size(), exp_q.size());
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [23:0] px;
    int          t0;
    int          off;

    rst_n = 1'b0;
    din   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset outputs", {pix_valid, frame_done, err, busy, pix_data, pix_addr}, 64'd0);
    rst_n = 1'b1;
    drive(1'b0, 5000);
    check("sync busy", busy, 1'b0);

    // Reference pixel at nominal timing
    px = 24'h0F1F01;
    for (int i = 23; i >= 0; i--) begin
      if (px[i]) send_bit(80, 45);
      else       send_bit(35, 90);
      if (i == 12) check("req027 busy mid", busy, m_inframe);
    end
    drive(1'b0, 5000);
    check_events("req027");
    check("req027 hold data", pix_data, m_last);
    check("req027 addr clear", pix_addr, 6'd0);
    check("req027 busy end", busy, m_inframe);

    // 65 pixels in one frame: address wraps; first pixel uses boundary widths
    px = 24'($urandom);
    for (int i = 23; i >= 0; i--) begin
      if (px[i]) send_bit(($urandom % 2) ? 60 : 120, int'($urandom_range(4, 20)));
      else       send_bit(($urandom % 2) ? 15 : 59, int'($urandom_range(4, 20)));
    end
    for (int p = 1; p < 65; p++) begin
      px = 24'($urandom) & 24'h800001;
      for (int i = 23; i >= 0; i--) send_bit(px[i] ? 60 : 15, 4);
    end
    check("req028 busy mid", busy, m_inframe);
    drive(1'b0, 5000);
    check_events("req028");
    check("req028 hold data", pix_data, m_last);

    // Runt pulse, 4999-cycle gap inside a frame, partial pixel at frame end
    for (int i = 0; i < 3; i++) send_fast(1'($urandom));
    send_bit(14, 20);
    for (int i = 0; i < 5; i++) send_fast(1'($urandom));
    drive(1'b1, int'($urandom_range(15, 90)));
    drive(1'b0, 4999);
    for (int i = 0; i < 6; i++) send_fast(1'($urandom));
    check("req029 busy mid", busy, m_inframe);
    drive(1'b0, 5000);
    check_events("req029");
    check("req029 busy end", busy, m_inframe);

    // Reset mid-pixel, then resynchronisation and a glitch inside a low phase
    for (int i = 0; i < 10; i++) send_fast(1'($urandom));
    rst_n = 1'b0;
    din   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("req031 reset outputs", {pix_valid, frame_done, err, busy, pix_data, pix_addr}, 64'd0);
    check("req031 no strobes", 64'(obs_q.size()), 64'(exp_q.size()));
    obs_q.delete();
    rst_n = 1'b1;
    drive(1'b0, 100);
    send_pixel(24'($urandom));
    drive(1'b0, 5000);
    send_pixel(24'($urandom));
    for (int i = 0; i < 4; i++) send_fast(1'($urandom));
    drive(1'b0, 40);
    glitch();
    drive(1'b0, 40);
    for (int i = 0; i < 20; i++) send_fast(1'($urandom));
    drive(1'b0, 5000);
    check_events("req031_032");

    // Stuck-high line: error at width 121, then bits ignored until a full gap
    t0 = cyc;
    drive(1'b1, 200);
    drive(1'b0, 20);
    send_pixel(24'($urandom));
    drive(1'b0, 100);
    off = (obs_q.size() > 0) ? obs_q[0].cyc - t0 : -1;
    check("req030 err cycle", off, LAT + T_HIGH_MAX + 1);
    check_events("req030");
    check("req030 busy", busy, m_inframe);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
